// File: rtl/hline_zbuff_ctrl.sv
// Horizontal-line z-buffer controller.
// Streams a line in CHUNK_W-pixel chunks: burst-load z and colour, interpolate
// z one pixel per cycle with a selectable depth test, then burst-write back.
module hline_zbuff_ctrl #(
   parameter int unsigned CHUNK_W = 256,
   parameter int unsigned BEAT_W  = 4,
   parameter int unsigned X_W     = 16
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           start,
   input  logic [31:0]    fb_addr,
   input  logic [31:0]    zbuff_addr,
   input  logic [31:0]    dx,
   input  logic [31:0]    z1,
   input  logic [31:0]    slope,
   input  logic [31:0]    rem,
   input  logic [31:0]    err,
   input  logic [31:0]    rgbx,
   input  logic [1:0]     depth_func,
   input  logic           z_write_en,
   input  logic           axi_done,
   output logic           rd_req,
   output logic           wr_req,
   output logic [31:0]    addr,
   output logic           axi_bus_to_z_fifo,
   output logic           axi_bus_to_f_fifo,
   input  logic [31:0]    z_fifo_in,
   input  logic [31:0]    f_fifo_in,
   output logic           read_in_fifos,
   output logic           write_z_out,
   output logic           write_f_out,
   output logic [31:0]    z_out,
   output logic [31:0]    f_out,
   output logic           pass_mask,
   output logic           read_z_out_fifo,
   output logic           read_f_out_fifo,
   output logic           busy,
   output logic           done,
   output logic [X_W-1:0] pass_cnt,
   output logic [3:0]     curr_state
);

   localparam int unsigned NBEATS      = CHUNK_W / BEAT_W;
   localparam int unsigned BEAT_BYTES  = BEAT_W * 4;
   localparam int unsigned CHUNK_BYTES = CHUNK_W * 4;
   localparam int unsigned IDX_W       = $clog2(CHUNK_W) + 1;
   localparam int unsigned BCNT_W      = $clog2(NBEATS) + 1;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_INIT   = 4'd1,
      S_LOOP   = 4'd2,
      S_LOAD_Z = 4'd3,
      S_LOAD_F = 4'd4,
      S_INTERP = 4'd5,
      S_WR_Z   = 4'd6,
      S_WR_F   = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t              state;
   logic [31:0]         off;
   logic [31:0]         base;
   logic signed [32:0]  remain;
   logic [IDX_W-1:0]    len;
   logic [IDX_W-1:0]    idx;
   logic [BCNT_W-1:0]   beat;
   logic [31:0]         zsum;
   logic signed [31:0]  err_acc;

   logic                in_span;
   logic                depth_ok;
   logic                pass_c;
   logic                last_beat;
   logic signed [31:0]  err_next;
   logic                err_over;
   logic [31:0]         slope_sgn;
   logic [31:0]         zstep;

   // Depth test and Bresenham step for the current pixel
   always_comb begin
      in_span   = (idx < len);
      last_beat = (beat == BCNT_W'(NBEATS - 1));
      case (depth_func)
         2'd0:    depth_ok = (zsum <  z_fifo_in);
         2'd1:    depth_ok = (zsum <= z_fifo_in);
         2'd2:    depth_ok = 1'b1;
         default: depth_ok = 1'b0;
      endcase
      pass_c    = in_span && depth_ok;
      err_next  = err_acc + $signed(rem);
      err_over  = (err_next > $signed(dx));
      slope_sgn = (slope == 32'd0) ? 32'd0 : (slope[31] ? 32'hFFFF_FFFF : 32'd1);
      zstep     = err_over ? (slope + slope_sgn) : slope;
   end

   // State register and datapath registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= S_IDLE;
         off      <= '0;
         base     <= '0;
         remain   <= '0;
         len      <= '0;
         idx      <= '0;
         beat     <= '0;
         zsum     <= '0;
         err_acc  <= '0;
         pass_cnt <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) state <= S_INIT;
            end
            S_INIT: begin
               zsum     <= z1;
               err_acc  <= $signed(err);
               remain   <= $signed({1'b0, dx});
               off      <= '0;
               base     <= '0;
               pass_cnt <= '0;
               state    <= S_LOOP;
            end
            S_LOOP: begin
               if (remain <= 33'sd0) begin
                  state <= S_DONE;
               end else begin
                  if (remain >= $signed(33'(CHUNK_W))) len <= IDX_W'(CHUNK_W);
                  else                                 len <= IDX_W'(remain);
                  remain <= remain - $signed(33'(CHUNK_W));
                  beat   <= '0;
                  idx    <= '0;
                  state  <= S_LOAD_Z;
               end
            end
            S_LOAD_Z, S_LOAD_F, S_WR_Z, S_WR_F: begin
               if (axi_done) begin
                  if (last_beat) begin
                     beat <= '0;
                     off  <= base;
                     case (state)
                        S_LOAD_Z: state <= S_LOAD_F;
                        S_LOAD_F: state <= S_INTERP;
                        S_WR_Z:   state <= S_WR_F;
                        default: begin
                           off   <= base + 32'(CHUNK_BYTES);
                           base  <= base + 32'(CHUNK_BYTES);
                           state <= S_LOOP;
                        end
                     endcase
                  end else begin
                     beat <= beat + BCNT_W'(1);
                     off  <= off + 32'(BEAT_BYTES);
                  end
               end
            end
            S_INTERP: begin
               if (in_span) begin
                  zsum    <= zsum + zstep;
                  err_acc <= err_over ? (err_next - $signed(dx)) : err_next;
               end
               if (pass_c) pass_cnt <= pass_cnt + X_W'(1);
               if (idx == IDX_W'(CHUNK_W - 1)) begin
                  idx   <= '0;
                  state <= z_write_en ? S_WR_Z : S_WR_F;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output decode from the registered state
   always_comb begin
      rd_req            = 1'b0;
      wr_req            = 1'b0;
      addr              = 32'd0;
      axi_bus_to_z_fifo = 1'b0;
      axi_bus_to_f_fifo = 1'b0;
      read_in_fifos     = 1'b0;
      write_z_out       = 1'b0;
      write_f_out       = 1'b0;
      z_out             = 32'd0;
      f_out             = 32'd0;
      pass_mask         = 1'b0;
      read_z_out_fifo   = 1'b0;
      read_f_out_fifo   = 1'b0;
      busy              = (state != S_IDLE) && (state != S_DONE);
      done              = (state == S_DONE);
      curr_state        = state;
      case (state)
         S_LOAD_Z: begin
            rd_req            = !axi_done;
            axi_bus_to_z_fifo = 1'b1;
            addr              = zbuff_addr + off;
         end
         S_LOAD_F: begin
            rd_req            = !axi_done;
            axi_bus_to_f_fifo = 1'b1;
            addr              = fb_addr + off;
         end
         S_INTERP: begin
            read_in_fifos = 1'b1;
            write_f_out   = 1'b1;
            write_z_out   = z_write_en;
            pass_mask     = pass_c;
            z_out         = (pass_c && z_write_en) ? zsum : z_fifo_in;
            f_out         = pass_c ? rgbx : f_fifo_in;
         end
         S_WR_Z: begin
            wr_req          = !axi_done;
            read_z_out_fifo = 1'b1;
            addr            = zbuff_addr + off;
         end
         S_WR_F: begin
            wr_req          = !axi_done;
            read_f_out_fifo = 1'b1;
            addr            = fb_addr + off;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// Bench for hline_zbuff_ctrl: memory/FIFO bus model plus a per-pixel line model.
module tb_hline_zbuff_ctrl;

   localparam int unsigned CHUNK_W = 256;
   localparam int unsigned BEAT_W  = 4;
   localparam int unsigned X_W     = 16;
   localparam int unsigned NBEATS  = CHUNK_W / BEAT_W;
   localparam logic [31:0] ZB      = 32'h1000_0000;
   localparam logic [31:0] FB      = 32'h2000_0000;

   logic           clk = 1'b0;
   logic           nreset;
   logic           start;
   logic [31:0]    fb_addr, zbuff_addr, dx, z1, slope, rem, err, rgbx;
   logic [1:0]     depth_func;
   logic           z_write_en;
   logic           axi_done;
   logic           rd_req, wr_req;
   logic [31:0]    addr;
   logic           axi_bus_to_z_fifo, axi_bus_to_f_fifo;
   logic [31:0]    z_fifo_in, f_fifo_in;
   logic           read_in_fifos, write_z_out, write_f_out;
   logic [31:0]    z_out, f_out;
   logic           pass_mask, read_z_out_fifo, read_f_out_fifo;
   logic           busy, done;
   logic [X_W-1:0] pass_cnt;
   logic [3:0]     curr_state;

   hline_zbuff_ctrl #(.CHUNK_W(CHUNK_W), .BEAT_W(BEAT_W), .X_W(X_W)) dut (
      .clk(clk), .nreset(nreset), .start(start),
      .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .dx(dx), .z1(z1),
      .slope(slope), .rem(rem), .err(err), .rgbx(rgbx),
      .depth_func(depth_func), .z_write_en(z_write_en), .axi_done(axi_done),
      .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
      .axi_bus_to_z_fifo(axi_bus_to_z_fifo), .axi_bus_to_f_fifo(axi_bus_to_f_fifo),
      .z_fifo_in(z_fifo_in), .f_fifo_in(f_fifo_in),
      .read_in_fifos(read_in_fifos), .write_z_out(write_z_out), .write_f_out(write_f_out),
      .z_out(z_out), .f_out(f_out), .pass_mask(pass_mask),
      .read_z_out_fifo(read_z_out_fifo), .read_f_out_fifo(read_f_out_fifo),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .curr_state(curr_state)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] zmem [logic [31:0]];
   logic [31:0] fmem [logic [31:0]];
   logic [31:0] zexp [logic [31:0]];
   logic [31:0] fexp [logic [31:0]];
   logic [31:0] zin_q[$], fin_q[$], zout_q[$], fout_q[$], zaddr_log[$];
   int          rd_beats, wr_z_beats, wr_f_beats, wz_pushes, mask_ones;
   bit          any_req;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // AXI slave, in-FIFOs and out-FIFOs around the DUT
   task automatic bus_model();
      bit          pop_pend;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         pop_pend = 1'b0;
         if (rd_req || wr_req) any_req = 1'b1;
         if (read_in_fifos) begin
            mask_ones += int'(pass_mask);
            if (write_z_out) begin zout_q.push_back(z_out); wz_pushes++; end
            if (write_f_out) fout_q.push_back(f_out);
            pop_pend = 1'b1;
         end
         if ((rd_req || wr_req) && ($urandom_range(3) != 0)) begin
            a = addr;
            if (axi_bus_to_z_fifo) begin
               zaddr_log.push_back(a);
               rd_beats++;
               for (int k = 0; k < int'(BEAT_W); k++)
                  zin_q.push_back(zmem.exists(a + 32'(4*k)) ? zmem[a + 32'(4*k)] : 32'd0);
            end else if (axi_bus_to_f_fifo) begin
               rd_beats++;
               for (int k = 0; k < int'(BEAT_W); k++)
                  fin_q.push_back(fmem.exists(a + 32'(4*k)) ? fmem[a + 32'(4*k)] : 32'd0);
            end else if (read_z_out_fifo) begin
               wr_z_beats++;
               for (int k = 0; k < int'(BEAT_W); k++)
                  zmem[a + 32'(4*k)] = (zout_q.size() > 0) ? zout_q.pop_front() : 32'hDEAD_BEEF;
            end else if (read_f_out_fifo) begin
               wr_f_beats++;
               for (int k = 0; k < int'(BEAT_W); k++)
                  fmem[a + 32'(4*k)] = (fout_q.size() > 0) ? fout_q.pop_front() : 32'hDEAD_BEEF;
            end
            axi_done = 1'b1;
         end
         @(posedge clk);
         #1;
         axi_done = 1'b0;
         if (pop_pend) begin
            if (zin_q.size() > 0) void'(zin_q.pop_front());
            if (fin_q.size() > 0) void'(fin_q.pop_front());
         end
         z_fifo_in = (zin_q.size() > 0) ? zin_q[0] : 32'd0;
         f_fifo_in = (fin_q.size() > 0) ? fin_q[0] : 32'd0;
      end
   endtask

   task automatic clear_bus();
      zin_q.delete(); fin_q.delete(); zout_q.delete(); fout_q.delete(); zaddr_log.delete();
      rd_beats = 0; wr_z_beats = 0; wr_f_beats = 0; wz_pushes = 0; mask_ones = 0;
      any_req = 1'b0;
   endtask

   // Load memories, predict the result pixel by pixel, run the line, compare
   task automatic run_line(input logic [31:0] l_dx, input logic [31:0] l_z1,
                           input logic [31:0] l_slope, input logic [31:0] l_rem,
                           input logic [31:0] l_err, input logic [1:0] l_df,
                           input logic l_zwe, input int zmode, input logic [31:0] zconst,
                           input string tag);
      int          nch, npix, pc, e, sg, cyc, zmis, fmis;
      logic [31:0] zs, zold, za;
      bit          pass;
      @(negedge clk);
      dx = l_dx; z1 = l_z1; slope = l_slope; rem = l_rem; err = l_err;
      depth_func = l_df; z_write_en = l_zwe; rgbx = $urandom;
      fb_addr = FB; zbuff_addr = ZB;
      nch  = (int'(l_dx) + int'(CHUNK_W) - 1) / int'(CHUNK_W);
      npix = (nch + 1) * int'(CHUNK_W);
      zmem.delete(); fmem.delete();
      for (int p = 0; p < npix; p++) begin
         zmem[ZB + 32'(4*p)] = (zmode != 0) ? zconst : l_z1 + 32'($urandom_range(0, 12000)) - 32'd6000;
         fmem[FB + 32'(4*p)] = $urandom;
      end
      zexp = zmem;
      fexp = fmem;
      zs = l_z1; e = int'($signed(l_err)); pc = 0;
      sg = ($signed(l_slope) > 0) ? 1 : (($signed(l_slope) < 0) ? -1 : 0);
      for (int p = 0; p < int'(l_dx); p++) begin
         za   = ZB + 32'(4*p);
         zold = zexp[za];
         case (l_df)
            2'd0:    pass = (zs <  zold);
            2'd1:    pass = (zs <= zold);
            2'd2:    pass = 1'b1;
            default: pass = 1'b0;
         endcase
         if (pass) begin
            if (l_zwe) zexp[za] = zs;
            fexp[FB + 32'(4*p)] = rgbx;
            pc++;
         end
         e = e + int'($signed(l_rem));
         if (e > int'(l_dx)) begin
            zs = zs + l_slope + 32'(sg);
            e  = e - int'(l_dx);
         end else begin
            zs = zs + l_slope;
         end
      end
      clear_bus();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000 * (nch + 1) + 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " pass_cnt"}, 32'(pass_cnt), 32'(pc));
      chk({tag, " mask_ones"}, 32'(mask_ones), 32'(pc));
      zmis = 0; fmis = 0;
      for (int p = 0; p < npix; p++) begin
         za = ZB + 32'(4*p);
         if (!zmem.exists(za) || zmem[za] !== zexp[za]) zmis++;
         za = FB + 32'(4*p);
         if (!fmem.exists(za) || fmem[za] !== fexp[za]) fmis++;
      end
      chk({tag, " zbuf_mismatches"}, 32'(zmis), 32'd0);
      chk({tag, " fbuf_mismatches"}, 32'(fmis), 32'd0);
      chk({tag, " zbuf_size"}, 32'(zmem.num()), 32'(npix));
      chk({tag, " fbuf_size"}, 32'(fmem.num()), 32'(npix));
      chk({tag, " read_beats"}, 32'(rd_beats), 32'(2 * nch * int'(NBEATS)));
      chk({tag, " wr_f_beats"}, 32'(wr_f_beats), 32'(nch * int'(NBEATS)));
      chk({tag, " wr_z_beats"}, 32'(wr_z_beats), l_zwe ? 32'(nch * int'(NBEATS)) : 32'd0);
      chk({tag, " z_out_pushes"}, 32'(wz_pushes), l_zwe ? 32'(nch * int'(CHUNK_W)) : 32'd0);
   endtask

   logic [31:0] r_dx, r_rem, r_err;
   int          cyc;

   initial begin
      nreset = 1'b0; start = 1'b0; axi_done = 1'b0;
      fb_addr = FB; zbuff_addr = ZB; dx = '0; z1 = '0; slope = '0; rem = '0; err = '0;
      rgbx = '0; depth_func = '0; z_write_en = 1'b1; z_fifo_in = '0; f_fifo_in = '0;
      clear_bus();
      fork bus_model(); join_none
      repeat (3) @(negedge clk);

      // reset state
      chk("rst curr_state", 32'(curr_state), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst rd_wr_req", 32'({rd_req, wr_req}), 32'd0);
      chk("rst addr", addr, 32'd0);
      chk("rst pass_cnt", 32'(pass_cnt), 32'd0);
      nreset = 1'b1;
      @(negedge clk);
      chk("idle busy", 32'(busy), 32'd0);

      // empty line: INIT, LOOP, DONE with no bus traffic
      dx = 32'd0;
      clear_bus();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("dx0 c1 busy", 32'(busy), 32'd1);
      chk("dx0 c1 done", 32'(done), 32'd0);
      @(negedge clk);
      chk("dx0 c2 done", 32'(done), 32'd0);
      @(negedge clk);
      chk("dx0 c3 done", 32'(done), 32'd1);
      chk("dx0 pass_cnt", 32'(pass_cnt), 32'd0);
      chk("dx0 any_req", 32'(any_req), 32'd0);
      run_line(32'd0, 32'd1000, 32'd3, 32'd0, 32'd0, 2'd0, 1'b1, 0, 32'd0, "dx0");

      // short LESS line against a flat z-buffer
      run_line(32'd5, 32'd100, 32'd10, 32'd0, 32'd0, 2'd0, 1'b1, 1, 32'd120, "dx5");
      chk("dx5 pass_cnt_lit", 32'(pass_cnt), 32'd2);

      // two chunks, second base 1024 bytes further on
      run_line(32'd300, 32'd50000, 32'hFFFF_FFF9, 32'd97, 32'hFFFF_FF6A, 2'd1, 1'b1, 0, 32'd0, "dx300");
      chk("dx300 chunk2_base", (zaddr_log.size() > int'(NBEATS)) ? zaddr_log[NBEATS] : 32'hFFFF_FFFF,
          ZB + 32'd1024);

      // equal depths across the four functions
      run_line(32'd10, 32'd500, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 1, 32'd500, "eq_less");
      chk("eq_less lit", 32'(pass_cnt), 32'd0);
      run_line(32'd10, 32'd500, 32'd0, 32'd0, 32'd0, 2'd1, 1'b1, 1, 32'd500, "eq_lequal");
      chk("eq_lequal lit", 32'(pass_cnt), 32'd10);
      run_line(32'd10, 32'd500, 32'd5, 32'd3, 32'd0, 2'd2, 1'b1, 0, 32'd0, "always");
      chk("always lit", 32'(pass_cnt), 32'd10);
      run_line(32'd10, 32'd500, 32'd5, 32'd3, 32'd0, 2'd3, 1'b1, 0, 32'd0, "never");
      chk("never lit", 32'(pass_cnt), 32'd0);

      // z writes disabled
      run_line(32'd4, 32'd700, 32'd1, 32'd0, 32'd0, 2'd2, 1'b0, 0, 32'd0, "nozw");
      chk("nozw lit", 32'(pass_cnt), 32'd4);

      // asynchronous reset in the middle of the colour load
      @(negedge clk);
      dx = 32'd300; z1 = 32'd1000; slope = 32'd1; rem = 32'd0; err = 32'd0;
      depth_func = 2'd0; z_write_en = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (axi_bus_to_f_fifo !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("midrst reached_load_f", 32'(axi_bus_to_f_fifo), 32'd1);
      @(posedge clk);
      #3 nreset = 1'b0;
      #1;
      chk("midrst curr_state", 32'(curr_state), 32'd0);
      chk("midrst busy_done", 32'({busy, done}), 32'd0);
      chk("midrst rd_req", 32'(rd_req), 32'd0);
      chk("midrst addr", addr, 32'd0);
      chk("midrst route", 32'({axi_bus_to_z_fifo, axi_bus_to_f_fifo}), 32'd0);
      chk("midrst pass_cnt", 32'(pass_cnt), 32'd0);
      clear_bus();
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;
      run_line(32'd300, 32'd1000, 32'd1, 32'd0, 32'd0, 2'd0, 1'b1, 0, 32'd0, "after_rst");

      // randomized lines
      for (int t = 0; t < 8; t++) begin
         r_dx  = 32'($urandom_range(1, 520));
         r_rem = 32'($urandom_range(0, int'(r_dx)));
         r_err = 32'd0 - 32'($urandom_range(0, int'(r_dx)));
         run_line(r_dx, 32'd100000 + 32'($urandom_range(0, 50000)),
                  32'($urandom_range(0, 40)) - 32'd20, r_rem, r_err,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 32'd0,
                  $sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
